// File: rtl/test_status_monitor.sv
// test_status_monitor: end-of-test verdict from writes to the status register,
// with saturating cycle and retire counters over the running phase.
module test_status_monitor #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int SETTLE_CYCLES  = 4,
    parameter int STATUS_REG     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        retire_valid,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [30:0] fail_code,
    output logic [31:0] status_value,
    output logic [31:0] cycle_count,
    output logic [31:0] retire_count
);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_SETTLE,
        ST_PASS,
        ST_FAIL,
        ST_TMO
    } state_t;

    localparam logic [4:0]  STAT_ADDR   = 5'(STATUS_REG);
    localparam logic [31:0] TMO_LAST    = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);

    state_t      state;
    state_t      state_nx;
    logic [31:0] settle_cnt;
    logic [31:0] settle_nx;

    logic sw;
    logic val_pass;
    logic val_fail;
    logic active;
    logic tmo_hit;
    logic settle_end;

    assign sw         = wb_en && (wb_addr == STAT_ADDR) && (wb_addr != 5'd0);
    assign val_pass   = (wb_data == 32'd1);
    assign val_fail   = wb_data[0] && !val_pass;
    assign active     = (state == ST_RUN) || (state == ST_SETTLE);
    // >= keeps timeout armed after a pass write lands on the last cycle
    assign tmo_hit    = (cycle_count >= TMO_LAST);
    assign settle_end = (settle_cnt == SETTLE_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_RUN;
            settle_cnt <= '0;
        end else begin
            state      <= state_nx;
            settle_cnt <= settle_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        settle_nx = settle_cnt;
        unique case (state)
            ST_RUN: begin
                if (sw && val_fail) begin
                    state_nx = ST_FAIL;
                end else if (sw && val_pass) begin
                    state_nx  = ST_SETTLE;
                    settle_nx = '0;
                end else if (tmo_hit) begin
                    state_nx = ST_TMO;
                end
            end
            ST_SETTLE: begin
                if (sw && val_fail) begin
                    state_nx = ST_FAIL;
                end else if (sw && val_pass) begin
                    settle_nx = '0;
                end else if (sw) begin
                    state_nx  = ST_RUN;
                    settle_nx = '0;
                end else if (settle_end) begin
                    state_nx = ST_PASS;
                end else if (tmo_hit) begin
                    state_nx = ST_TMO;
                end else begin
                    settle_nx = settle_cnt + 32'd1;
                end
            end
            ST_PASS, ST_FAIL, ST_TMO: begin
                state_nx = state;
            end
            default: begin
                state_nx = ST_RUN;
            end
        endcase
    end

    always_comb begin
        done    = 1'b0;
        pass    = 1'b0;
        fail    = 1'b0;
        timeout = 1'b0;
        unique case (state)
            ST_PASS: begin
                done = 1'b1;
                pass = 1'b1;
            end
            ST_FAIL: begin
                done = 1'b1;
                fail = 1'b1;
            end
            ST_TMO: begin
                done    = 1'b1;
                fail    = 1'b1;
                timeout = 1'b1;
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            status_value <= '0;
            fail_code    <= '0;
            cycle_count  <= '0;
            retire_count <= '0;
        end else if (active) begin
            if (sw) begin
                status_value <= wb_data;
            end
            if (state_nx == ST_FAIL) begin
                fail_code <= wb_data[31:1];
            end
            if (cycle_count != '1) begin
                cycle_count <= cycle_count + 32'd1;
            end
            if (retire_valid && (retire_count != '1)) begin
                retire_count <= retire_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_test_status_monitor.sv
// tb_test_status_monitor: directed and random checks of the end-of-test
// monitor against a pending-pass/elapsed-cycle reference model.
module tb_test_status_monitor;

    localparam int TMO    = 50;
    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        retire_valid = 1'b0;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [30:0] fail_code;
    logic [31:0] status_value;
    logic [31:0] cycle_count;
    logic [31:0] retire_count;

    test_status_monitor #(
        .TIMEOUT_CYCLES(TMO),
        .SETTLE_CYCLES (SETTLE),
        .STATUS_REG    (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .retire_valid(retire_valid),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .timeout     (timeout),
        .fail_code   (fail_code),
        .status_value(status_value),
        .cycle_count (cycle_count),
        .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // model: verdict flags plus the cycle index of the last pending pass write
    bit          m_done;
    bit          m_pass;
    bit          m_fail;
    bit          m_tmo;
    logic [30:0] m_code;
    logic [31:0] m_status;
    int          m_cyc;
    int          m_ret;
    int          m_pend;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_done   = 1'b0;
        m_pass   = 1'b0;
        m_fail   = 1'b0;
        m_tmo    = 1'b0;
        m_code   = '0;
        m_status = '0;
        m_cyc    = 0;
        m_ret    = 0;
        m_pend   = -1;
    endtask

    task automatic model_step(input bit en, input logic [4:0] a,
                              input logic [31:0] d, input bit r);
        bit sw;
        sw = en && (a == 5'd3);
        if (m_done) return;
        if (sw) m_status = d;
        if (sw && d[0] && d != 32'd1) begin
            m_done = 1'b1;
            m_fail = 1'b1;
            m_code = d[31:1];
        end else if (sw && d == 32'd1) begin
            m_pend = m_cyc;
        end else if (sw && m_pend >= 0) begin
            m_pend = -1;
        end else if (m_pend >= 0 && m_cyc - m_pend == SETTLE) begin
            m_done = 1'b1;
            m_pass = 1'b1;
        end else if (m_cyc >= TMO - 1) begin
            m_done = 1'b1;
            m_fail = 1'b1;
            m_tmo  = 1'b1;
        end
        m_cyc++;
        if (r) m_ret++;
    endtask

    task automatic check_all();
        chk("done", {31'b0, done}, {31'b0, m_done});
        chk("pass", {31'b0, pass}, {31'b0, m_pass});
        chk("fail", {31'b0, fail}, {31'b0, m_fail});
        chk("timeout", {31'b0, timeout}, {31'b0, m_tmo});
        chk("fail_code", {1'b0, fail_code}, {1'b0, m_code});
        chk("status_value", status_value, m_status);
        chk("cycle_count", cycle_count, 32'(m_cyc));
        chk("retire_count", retire_count, 32'(m_ret));
    endtask

    task automatic cyc(input bit en, input logic [4:0] a,
                       input logic [31:0] d, input bit r);
        wb_en        = en;
        wb_addr      = a;
        wb_data      = d;
        retire_valid = r;
        model_step(en, a, d, r);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cyc(1'b1, a, d, 1'b0);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        wb_en        = 1'b0;
        wb_addr      = '0;
        wb_data      = '0;
        retire_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        logic [4:0]  ra;
        logic [31:0] rd;
        int          n;

        // pass after settle window
        do_reset();
        idle(3);
        wr(5'd3, 32'd2);
        idle(5);
        wr(5'd3, 32'd1);
        idle(3);
        chk("pass_early", {31'b0, pass}, 32'd0);
        idle(1);
        chk("pass_dir", {31'b0, pass}, 32'd1);
        chk("pass_status", status_value, 32'd1);
        chk("pass_nofail", {31'b0, fail}, 32'd0);

        // immediate fail, later writes ignored
        do_reset();
        idle(4);
        wr(5'd3, 32'd7);
        chk("fail_dir", {31'b0, fail}, 32'd1);
        chk("fail_code_dir", {1'b0, fail_code}, 32'd3);
        chk("fail_notmo", {31'b0, timeout}, 32'd0);
        wr(5'd3, 32'd1);
        idle(2);
        chk("fail_frozen", status_value, 32'd7);
        chk("fail_nopass", {31'b0, pass}, 32'd0);

        // fail during settle
        do_reset();
        idle(9);
        wr(5'd3, 32'd1);
        idle(1);
        wr(5'd3, 32'd9);
        chk("settle_fail_code", {1'b0, fail_code}, 32'd4);
        chk("settle_fail_nopass", {31'b0, pass}, 32'd0);

        // timeout with retires every other cycle
        do_reset();
        for (int i = 0; i < 49; i++) cyc(1'b0, 5'd0, 32'd0, (i % 2) == 0);
        chk("tmo_early", {31'b0, timeout}, 32'd0);
        cyc(1'b0, 5'd0, 32'd0, 1'b0);
        chk("tmo_dir", {31'b0, timeout}, 32'd1);
        chk("tmo_cycles", cycle_count, 32'd50);
        chk("tmo_retires", retire_count, 32'd25);
        chk("tmo_code", {1'b0, fail_code}, 32'd0);

        // non-status registers, then reset mid-settle
        do_reset();
        wr(5'd0, 32'd1);
        wr(5'd4, 32'd1);
        chk("other_reg_status", status_value, 32'd0);
        wr(5'd3, 32'd1);
        idle(2);
        do_reset();
        chk("rst_mid_cycles", cycle_count, 32'd0);
        chk("rst_mid_status", status_value, 32'd0);
        idle(5);
        chk("rst_mid_nopass", {31'b0, pass}, 32'd0);
        wr(5'd3, 32'd7);
        chk("rst_then_fail", {31'b0, fail}, 32'd1);

        // fail write on the timeout cycle
        do_reset();
        idle(49);
        wr(5'd3, 32'd5);
        chk("edge_fail", {31'b0, fail}, 32'd1);
        chk("edge_notmo", {31'b0, timeout}, 32'd0);
        chk("edge_code", {1'b0, fail_code}, 32'd2);

        // pass write on the timeout cycle times out next cycle
        do_reset();
        idle(49);
        wr(5'd3, 32'd1);
        chk("edge_pass_wait", {31'b0, done}, 32'd0);
        idle(1);
        chk("edge_pass_tmo", {31'b0, timeout}, 32'd1);

        // even write drops back to run, new pass write completes
        do_reset();
        wr(5'd3, 32'd1);
        idle(1);
        wr(5'd3, 32'd6);
        idle(6);
        chk("even_nopass", {31'b0, pass}, 32'd0);
        wr(5'd3, 32'd1);
        idle(4);
        chk("even_repass", {31'b0, pass}, 32'd1);

        // random episodes
        for (int ep = 0; ep < 30; ep++) begin
            do_reset();
            n = int'($urandom_range(10, 70));
            for (int k = 0; k < n; k++) begin
                case ($urandom_range(0, 3))
                    0, 1:    ra = 5'd3;
                    2:       ra = 5'd0;
                    default: ra = 5'($urandom);
                endcase
                case ($urandom_range(0, 4))
                    0, 1:    rd = 32'd1;
                    2:       rd = $urandom & 32'hFFFF_FFFE;
                    3:       rd = $urandom | 32'd1;
                    default: rd = 32'd0;
                endcase
                cyc($urandom_range(0, 5) == 0, ra, rd, 1'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
